arb_req_queue: RTL and testbench
================================

Name: arb_req_queue

Overview:
- Upstream feeder for the team's round-robin arbiter (`arb`, WIDTH requesters, registered one-hot grant).
- Holds a small FIFO per requester and drives the arbiter's `request` vector from FIFO occupancy.
- Consumes the arbiter's one-hot `grant` to pop the granted FIFO into a single registered valid/ready output port tagged with the source index.
- Tolerates the arbiter's multi-cycle request-to-grant latency and stale grants.

Parameters:
- WIDTH, 4, number of requesters; must match the arbiter WIDTH.
- DW, 8, data width per entry.
- DEPTH, 4, entries per requester FIFO; power of two, >= 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  WIDTH  per-requester write strobe.
- in_ready  output  WIDTH  per-requester FIFO not full.
- in_data  input  WIDTH*DW  requester i data at bits [i*DW +: DW].
- request  output  WIDTH  to arbiter; bit i = FIFO i non-empty.
- grant  input  WIDTH  from arbiter; one-hot or zero.
- out_valid  output  1  output register holds an entry.
- out_ready  input  1  downstream accepts.
- out_data  output  DW  popped entry.
- out_port  output  $clog2(WIDTH)  source requester index of out_data.
- grant_drop  output  1  one-cycle pulse: a grant bit was set but nothing was popped.
- grant_err  output  1  sticky: grant had more than one bit set.

Behaviour:
- Reset:
  - All FIFO counts and pointers are 0.
  - out_valid=0, out_data=0, out_port=0, grant_drop=0, grant_err=0.
  - Consequently request=0 and in_ready=all ones in the first cycle after reset.
- Push: FIFO i writes in_data slice on (in_valid[i] && in_ready[i]).
- in_ready[i] = (count_i < DEPTH), from registered count. No full-bypass: a full FIFO refuses a push even if it pops in the same cycle.
- request[i] = (count_i != 0), combinational from registered count.
- Latency: the arbiter grants two cycles after sampling request. A grant may therefore refer to a FIFO that has since been emptied; this is legal.
- Output slot is free when (!out_valid || out_ready).
- Pop condition, each cycle: grant is one-hot with bit i set, count_i != 0, and the output slot is free. When it holds:
  - Head of FIFO i loads out_data.
  - out_port <= i, out_valid <= 1.
  - count_i is decremented.
- A pop on FIFO i and a push on FIFO i in the same cycle are both performed; count_i is unchanged.
- Pop from an empty FIFO never occurs; push and pop in the same cycle on an empty FIFO means push only.
- If out_valid && out_ready and no pop occurs, out_valid <= 0 next cycle.
- Output is a full-throughput register: a new entry may load on the same edge the old one is accepted.
- grant == 0: no action.
- grant one-hot, but FIFO empty or output slot busy: no pop, no state change, grant_drop=1 for one cycle. The grant is not retained; the arbiter will regrant.
- grant with two or more bits set: no pop; grant_err <= 1, held until reset; grant_drop=1.
- Each FIFO preserves order; pointers wrap modulo DEPTH.
- Reset mid-operation discards all FIFO contents and the output register entry.
- out_data/out_port hold their last value while out_valid=0; out_data is only meaningful when out_valid=1.

Test Plan:
1. Reset, then push 0xA1 on port 2 only. Required: request=4'b0100 next cycle. Drive grant=4'b0100 with out_ready=1 → next cycle out_valid=1, out_data=0xA1, out_port=2, request=0.
2. Fill port 0 with DEPTH=4 entries 0x10..0x13. Required: in_ready[0]=0. Fifth push is ignored. Four grants on bit 0 with out_ready=1 deliver 0x10,0x11,0x12,0x13 in order; then in_ready[0]=1.
3. Port 1 holds 1 entry; drive grant=4'b0010 on two consecutive cycles (stale second grant). Required: exactly one pop; grant_drop=1 on the second cycle; no underflow, count stays 0.
4. Hold out_ready=0 with out_valid=1 and apply grant=4'b0001 with FIFO 0 non-empty. Required: no pop, grant_drop=1, out_data unchanged, count_0 unchanged.
5. Apply grant=4'b0011. Required: no pop, grant_err=1 and stays 1 until reset, grant_drop pulse.
6. Connect to `arb`, all four ports continuously loaded with port-tagged data, out_ready=1. Required: out_port cycles 0→1→2→3 (rotation per arbiter). No entry lost or duplicated over 100 entries; reset mid-stream → out_valid=0 and request=0 on the following cycle.

Source files
------------

// File: rtl/arb_req_queue.sv
// Per-requester FIFOs feeding a round-robin arbiter; the granted FIFO
// pops into one registered valid/ready output tagged with its source.
module arb_req_queue #(
    parameter int WIDTH = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in_valid,
    output logic [WIDTH-1:0]             in_ready,
    input  logic [WIDTH*DW-1:0]          in_data,
    output logic [WIDTH-1:0]             request,
    input  logic [WIDTH-1:0]             grant,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    output logic [(WIDTH>1 ? $clog2(WIDTH) : 1)-1:0] out_port,
    output logic                         grant_drop,
    output logic                         grant_err
);
    localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [WIDTH][DEPTH];
    logic [AW-1:0] rd_q  [WIDTH];
    logic [AW-1:0] rd_d  [WIDTH];
    logic [AW-1:0] wr_q  [WIDTH];
    logic [AW-1:0] wr_d  [WIDTH];
    logic [CW-1:0] cnt_q [WIDTH];
    logic [CW-1:0] cnt_d [WIDTH];

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [PW-1:0] out_port_q, out_port_d;
    logic          drop_q, drop_d;
    logic          err_q, err_d;

    logic [WIDTH-1:0] push;
    logic [WIDTH-1:0] pop;
    logic             one_hot;
    logic             multi_hot;
    logic             slot_free;
    logic             pop_ok;
    logic [PW-1:0]    gidx;
    logic [DW-1:0]    head;

    always_comb begin
        in_ready = '0;
        request  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_ready[i] = cnt_q[i] < CW'(DEPTH);
            request[i]  = cnt_q[i] != '0;
        end
    end

    assign push      = in_valid & in_ready;
    assign one_hot   = $onehot(grant);
    assign multi_hot = (grant != '0) && !one_hot;
    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (grant[i]) gidx = PW'(i);
        end
    end

    // A stale grant (FIFO emptied since request was sampled) is simply dropped.
    assign pop_ok = one_hot && (cnt_q[gidx] != '0) && slot_free;
    assign pop    = pop_ok ? grant : '0;
    assign head   = mem_q[gidx][rd_q[gidx]];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            rd_d[i]  = rd_q[i];
            wr_d[i]  = wr_q[i];
            cnt_d[i] = cnt_q[i];
            if (push[i]) wr_d[i] = wr_q[i] + AW'(1);
            if (pop[i])  rd_d[i] = rd_q[i] + AW'(1);
            if (push[i] && !pop[i]) cnt_d[i] = cnt_q[i] + CW'(1);
            else if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - CW'(1);
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        if (pop_ok) begin
            out_valid_d = 1'b1;
            out_data_d  = head;
            out_port_d  = gidx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        drop_d = (grant != '0) && !pop_ok;
        err_d  = err_q || multi_hot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                rd_q[i]  <= rd_d[i];
                wr_q[i]  <= wr_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
        end
    end

    // Storage needs no reset: pointers and counts define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (!reset && push[i]) mem_q[i][wr_q[i]] <= in_data[i*DW +: DW];
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_port   = out_port_q;
    assign grant_drop = drop_q;
    assign grant_err  = err_q;
endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: directed plan scenarios plus randomized traffic
// against a queue-based reference model and a behavioural round-robin arbiter.
module tb_arb_req_queue;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  request;
    logic [3:0]  grant;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic        grant_drop;
    logic        grant_err;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] fq[4][$];
    logic       m_ov;
    logic [7:0] m_od;
    logic [1:0] m_op;
    logic       m_drop;
    logic       m_err;

    arb_req_queue #(.WIDTH(4), .DW(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .request(request), .grant(grant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_port(out_port),
        .grant_drop(grant_drop), .grant_err(grant_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] m_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = fq[i].size() != 0;
        return r;
    endfunction

    function automatic logic [3:0] m_rdy();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = fq[i].size() < DEPTH;
        return r;
    endfunction

    // Advance the reference model by one cycle, then clock the DUT.
    task automatic step();
        logic [3:0] acc;
        int nb;
        int gi;
        bit pop;
        if (reset) begin
            for (int i = 0; i < 4; i++) fq[i].delete();
            m_ov = 0; m_od = 0; m_op = 0; m_drop = 0; m_err = 0;
        end else begin
            for (int i = 0; i < 4; i++)
                acc[i] = in_valid[i] && (fq[i].size() < DEPTH);
            nb = $countones(grant);
            gi = 0;
            for (int i = 0; i < 4; i++) if (grant[i]) gi = i;
            pop = (nb == 1) && (fq[gi].size() != 0) && (!m_ov || out_ready);
            m_drop = (nb != 0) && !pop;
            if (nb > 1) m_err = 1;
            if (pop) begin
                m_od = fq[gi].pop_front();
                m_op = 2'(gi);
                m_ov = 1;
            end else if (out_ready) begin
                m_ov = 0;
            end
            for (int i = 0; i < 4; i++)
                if (acc[i]) fq[i].push_back(in_data[i*8 +: 8]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; grant = 0; in_data = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle(); out_ready = 1;
        step(); step();
        reset = 0;
        n_total++;
        if ({out_valid, out_data, out_port} !== 11'd0)
            $display("FAIL reset_out: got v=%b d=%h p=%0d want 0", out_valid, out_data, out_port);
        else n_pass++;
        n_total++;
        if ({grant_drop, grant_err} !== 2'b00)
            $display("FAIL reset_flags: got %b want 00", {grant_drop, grant_err});
        else n_pass++;
        n_total++;
        if (request !== 4'b0000 || in_ready !== 4'b1111)
            $display("FAIL reset_req_rdy: got req=%b rdy=%b want 0000/1111", request, in_ready);
        else n_pass++;
    endtask

    task automatic test_single();
        in_valid = 4'b0100; in_data = 32'h00A1_0000;
        step();
        idle();
        n_total++;
        if (request !== 4'b0100) $display("FAIL single_req: got %b want 0100", request);
        else n_pass++;
        grant = 4'b0100; out_ready = 1;
        step();
        grant = 0;
        n_total++;
        if (out_valid !== 1 || out_data !== 8'hA1 || out_port !== 2'd2 || request !== 4'b0)
            $display("FAIL single_pop: got v=%b d=%h p=%0d req=%b want 1/a1/2/0000",
                     out_valid, out_data, out_port, request);
        else n_pass++;
        step();
    endtask

    task automatic test_fill();
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b0001; in_data = 32'(8'h10 + 8'(k));
            step();
        end
        n_total++;
        if (in_ready[0] !== 1'b0) $display("FAIL fill_full: got in_ready0=%b want 0", in_ready[0]);
        else n_pass++;
        in_data = 32'h55;
        step();
        idle();
        for (int k = 0; k < 4; k++) begin
            grant = 4'b0001;
            step();
            n_total++;
            if (out_valid !== 1 || out_data !== 8'h10 + 8'(k) || out_port !== 2'd0)
                $display("FAIL fill_order%0d: got v=%b d=%h p=%0d want 1/%h/0",
                         k, out_valid, out_data, out_port, 8'h10 + 8'(k));
            else n_pass++;
        end
        grant = 0;
        step();
        n_total++;
        if (in_ready[0] !== 1'b1 || request[0] !== 1'b0)
            $display("FAIL fill_drain: got rdy0=%b req0=%b want 1/0", in_ready[0], request[0]);
        else n_pass++;
    endtask

    task automatic test_stale();
        out_ready = 1;
        in_valid = 4'b0010; in_data = 32'h0000_7700;
        step();
        idle();
        grant = 4'b0010;
        step();
        n_total++;
        if (out_data !== 8'h77 || out_port !== 2'd1 || grant_drop !== 0)
            $display("FAIL stale_first: got d=%h p=%0d drop=%b want 77/1/0", out_data, out_port, grant_drop);
        else n_pass++;
        step();
        n_total++;
        if (grant_drop !== 1 || request !== 4'b0 || out_valid !== 0 || in_ready !== 4'hF)
            $display("FAIL stale_second: got drop=%b req=%b v=%b rdy=%b want 1/0000/0/1111",
                     grant_drop, request, out_valid, in_ready);
        else n_pass++;
        grant = 0;
        step();
        n_total++;
        if (grant_drop !== 0) $display("FAIL stale_pulse: got drop=%b want 0", grant_drop);
        else n_pass++;
    endtask

    task automatic test_busy();
        out_ready = 1;
        in_valid = 4'b0001; in_data = 32'h31; step();
        in_data = 32'h32; step();
        idle();
        out_ready = 0; grant = 4'b0001;
        step();
        step();
        n_total++;
        if (grant_drop !== 1 || out_valid !== 1 || out_data !== 8'h31 || request[0] !== 1)
            $display("FAIL busy_hold: got drop=%b v=%b d=%h req0=%b want 1/1/31/1",
                     grant_drop, out_valid, out_data, request[0]);
        else n_pass++;
        out_ready = 1;
        step();
        n_total++;
        if (out_data !== 8'h32 || grant_drop !== 0 || request[0] !== 0)
            $display("FAIL busy_next: got d=%h drop=%b req0=%b want 32/0/0", out_data, grant_drop, request[0]);
        else n_pass++;
        grant = 0;
        step();
    endtask

    task automatic test_multi();
        out_ready = 1;
        in_valid = 4'b0011; in_data = 32'h0000_4544;
        step();
        idle();
        grant = 4'b0011;
        step();
        n_total++;
        if (grant_err !== 1 || grant_drop !== 1 || out_valid !== 0 || request !== 4'b0011)
            $display("FAIL multi_hit: got err=%b drop=%b v=%b req=%b want 1/1/0/0011",
                     grant_err, grant_drop, out_valid, request);
        else n_pass++;
        grant = 0;
        step(); step();
        n_total++;
        if (grant_err !== 1 || grant_drop !== 0)
            $display("FAIL multi_sticky: got err=%b drop=%b want 1/0", grant_err, grant_drop);
        else n_pass++;
        reset = 1; step(); reset = 0;
        n_total++;
        if (grant_err !== 0) $display("FAIL multi_clear: got err=%b want 0", grant_err);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [20:0] got, exp;
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 15))
                0, 1, 2, 3, 4: grant = 0;
                5:             grant = 4'($urandom) | 4'b0101;
                default:       grant = 4'b0001 << $urandom_range(0, 3);
            endcase
            step();
            got = {out_valid, out_data, out_port, request, in_ready, grant_drop, grant_err};
            exp = {m_ov, m_od, m_op, m_req(), m_rdy(), m_drop, m_err};
            n_total++;
            if (got !== exp) begin
                if (bad < 10)
                    $display("FAIL random_c%0d: got %h want %h", c, got, exp);
                bad++;
            end else n_pass++;
        end
        idle();
        reset = 1; step(); reset = 0;
    endtask

    task automatic test_arb_stream();
        logic [3:0] gp0, gp1, nx, rq, acc;
        int last = 3;
        int seq[4] = '{0, 0, 0, 0};
        int expseq[4] = '{0, 0, 0, 0};
        int got = 0;
        int prev = -1;
        int cyc = 0;
        int want;
        gp0 = 0; gp1 = 0;
        out_ready = 1; in_valid = 4'hF;
        while (got < 100 && cyc < 800) begin
            for (int i = 0; i < 4; i++)
                in_data[i*8 +: 8] = {2'(i), 6'(seq[i])};
            rq = m_req();
            nx = 0;
            for (int k = 1; k <= 4; k++) begin
                int j;
                j = (last + k) % 4;
                if (rq[j] && nx == 0) begin nx[j] = 1'b1; last = j; end
            end
            grant = gp1; gp1 = gp0; gp0 = nx;
            acc = m_rdy();
            step();
            for (int i = 0; i < 4; i++) if (acc[i]) seq[i]++;
            cyc++;
            if (out_valid === 1'b1) begin
                want = (prev < 0) ? 0 : (prev + 1) % 4;
                n_total++;
                if (out_port !== 2'(want) || out_data[7:6] !== out_port ||
                    out_data[5:0] !== 6'(expseq[want]))
                    $display("FAIL stream_e%0d: got p=%0d d=%h want p=%0d seq=%0d",
                             got, out_port, out_data, want, expseq[want] % 64);
                else n_pass++;
                expseq[want]++;
                prev = want;
                got++;
            end
        end
        n_total++;
        if (got < 100) $display("FAIL stream_timeout: got %0d entries want 100", got);
        else n_pass++;
        reset = 1;
        step();
        n_total++;
        if (out_valid !== 0 || request !== 4'b0)
            $display("FAIL stream_reset: got v=%b req=%b want 0/0000", out_valid, request);
        else n_pass++;
        reset = 0; idle();
        step();
    endtask

    initial begin
        reset = 1; out_ready = 1; idle();
        test_reset();
        test_single();
        test_fill();
        test_stale();
        test_busy();
        test_multi();
        test_random();
        test_arb_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
